dac_multich_seq: RTL and testbench

//  Parametrised multi-channel parallel-bus DAC write sequencer; successor to the single-channel DAC driver.

---
 rtl/dac_pkg.sv | 23 ++
 rtl/oneshot_universal.sv | 30 +++
 rtl/dac_multich_seq.sv | 159 +++++++++++++++
 tb/tb_dac_multich_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the multi-channel DAC write sequencer.
package dac_pkg;

    typedef enum logic [2:0] {
        ST_DLY,
        ST_SU,
        ST_WR,
        ST_HD,
        ST_LD
    } state_t;

    localparam int BTN_DEC_S = 5;
    localparam int BTN_INC_S = 4;
    localparam int BTN_DEC_M = 3;
    localparam int BTN_INC_M = 2;
    localparam int BTN_DEC_L = 1;
    localparam int BTN_INC_L = 0;

    function automatic int unsigned mid_val(input int unsigned dw);
        return 32'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/oneshot_universal.sv
// Synchronises raw inputs and emits a one-cycle pulse per rising edge on each bit.
// Pulse appears two cycles after the input rises; holding the input high gives no further pulses.
module oneshot_universal #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] pulse_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/dac_multich_seq.sv
// Multi-channel parallel-bus DAC write sequencer: button-edited per-channel values, scanned
// round-robin every frame with setup/strobe/hold timing, optional LDAC pulse and sawtooth ramp.
module dac_multich_seq
    import dac_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DW        = 8,
    parameter int T_DLY     = 200,
    parameter int T_SU      = 50,
    parameter int T_WR      = 30,
    parameter int T_HD      = 2,
    parameter int LDAC_SYNC = 1,
    parameter int STEP_S    = 1,
    parameter int STEP_M    = 2,
    parameter int STEP_L    = 8,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      btn_i,
    input  logic [CH_W-1:0] ch_sel_i,
    input  logic            mode_i,
    output logic            dac_csn_o,
    output logic            dac_wrn_o,
    output logic            dac_ldacn_o,
    output logic [CH_W-1:0] dac_addr_o,
    output logic [DW-1:0]   dac_d_o,
    output logic [DW-1:0]   led_out_o,
    output logic            frame_done_o
);

    localparam int       SW         = DW + 1;
    localparam logic     LDACN_IDLE = (LDAC_SYNC != 0);
    localparam logic [DW-1:0] MID   = DW'(mid_val(DW));

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [DW-1:0]   val_q [N_CH];
    logic [DW-1:0]   val_d [N_CH];
    logic            csn_q, wrn_q, ldacn_q, fd_q;
    logic [CH_W-1:0] addr_q;
    logic [DW-1:0]   d_q, led_q;
    logic [5:0]      btn_t;
    logic            sel_ok, frame_end, load_bus;
    logic            up, hit;
    logic [SW-1:0]   step, sum;
    logic [DW-1:0]   edited;

    oneshot_universal #(.WIDTH(6)) u_btn (
        .clk     (clk),
        .rst     (rst),
        .in_i    (btn_i),
        .pulse_o (btn_t)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        ch_d    = ch_q;
        unique case (state_q)
            ST_DLY: if (cnt_q == 16'(T_DLY - 1)) begin
                state_d = ST_SU;
                ch_d    = '0;
            end
            ST_SU: if (cnt_q == 16'(T_SU - 1)) state_d = ST_WR;
            ST_WR: if (cnt_q == 16'(T_WR - 1)) state_d = ST_HD;
            ST_HD: if (cnt_q == 16'(T_HD - 1)) begin
                if (int'(ch_q) < N_CH - 1) begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = ST_SU;
                end else begin
                    state_d = (LDAC_SYNC != 0) ? ST_LD : ST_DLY;
                end
            end
            ST_LD:   state_d = ST_DLY;
            default: state_d = ST_DLY;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    assign frame_end = (state_q != ST_DLY) && (state_d == ST_DLY);
    assign load_bus  = (state_d == ST_SU) && (state_q != ST_SU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DLY;
            cnt_q   <= '0;
            ch_q    <= '0;
            csn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            ldacn_q <= LDACN_IDLE;
            addr_q  <= '0;
            d_q     <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            // Bus strobes follow the next state so each pin changes exactly at the state boundary.
            csn_q   <= !(state_d == ST_SU || state_d == ST_WR || state_d == ST_HD);
            wrn_q   <= (state_d != ST_WR);
            ldacn_q <= (LDAC_SYNC != 0) ? (state_d != ST_LD) : 1'b0;
            fd_q    <= frame_end;
            if (load_bus) begin
                addr_q <= ch_d;
                d_q    <= val_q[ch_d];
            end
        end
    end

    assign sel_ok = int'(ch_sel_i) < N_CH;

    always_comb begin
        step = '0;
        up   = 1'b0;
        hit  = 1'b1;
        if      (btn_t[BTN_DEC_S]) step = SW'(STEP_S);
        else if (btn_t[BTN_INC_S]) begin step = SW'(STEP_S); up = 1'b1; end
        else if (btn_t[BTN_DEC_M]) step = SW'(STEP_M);
        else if (btn_t[BTN_INC_M]) begin step = SW'(STEP_M); up = 1'b1; end
        else if (btn_t[BTN_DEC_L]) step = SW'(STEP_L);
        else if (btn_t[BTN_INC_L]) begin step = SW'(STEP_L); up = 1'b1; end
        else hit = 1'b0;
    end

    always_comb begin
        val_d  = val_q;
        sum    = up ? ({1'b0, val_q[ch_sel_i]} + step) : ({1'b0, val_q[ch_sel_i]} - step);
        // Top bit is carry on increment and borrow on decrement.
        edited = sum[DW] ? (up ? '1 : '0) : sum[DW-1:0];
        if (sel_ok) begin
            if (mode_i) begin
                if (fd_q) val_d[ch_sel_i] = val_q[ch_sel_i] + DW'(1);
            end else if (hit) begin
                val_d[ch_sel_i] = edited;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) val_q[i] <= MID;
            led_q <= MID;
        end else begin
            val_q <= val_d;
            led_q <= sel_ok ? val_q[ch_sel_i] : '0;
        end
    end

    assign dac_csn_o    = csn_q;
    assign dac_wrn_o    = wrn_q;
    assign dac_ldacn_o  = ldacn_q;
    assign dac_addr_o   = addr_q;
    assign dac_d_o      = d_q;
    assign led_out_o    = led_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_dac_multich_seq.sv
// Directed bench for dac_multich_seq: cycle-exact first frame, reset abort, edits, priority, ramp.
module tb_dac_multich_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = '0;
    logic [0:0] ch_sel = '0;
    logic       mode = 1'b0;
    logic       dac_csn, dac_wrn, dac_ldacn, frame_done;
    logic [0:0] dac_addr;
    logic [7:0] dac_d, led_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       addr;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mval[2];
    logic       wrn_prev = 1'b1;

    dac_multich_seq #(
        .N_CH(2), .DW(8), .T_DLY(4), .T_SU(2), .T_WR(3), .T_HD(2), .LDAC_SYNC(1),
        .STEP_S(1), .STEP_M(2), .STEP_L(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_i        (btn),
        .ch_sel_i     (ch_sel),
        .mode_i       (mode),
        .dac_csn_o    (dac_csn),
        .dac_wrn_o    (dac_wrn),
        .dac_ldacn_o  (dac_ldacn),
        .dac_addr_o   (dac_addr),
        .dac_d_o      (dac_d),
        .led_out_o    (led_out),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each write strobe start is matched against the oldest expected bus word.
    always @(negedge clk) begin
        if (!rst && !dac_wrn && wrn_prev && exp_q.size() > 0) begin
            wr_t e;
            e = exp_q.pop_front();
            chk("bus_addr", 32'(dac_addr), 32'(e.addr));
            chk("bus_d", 32'(dac_d), 32'(e.d));
        end
        wrn_prev <= dac_wrn;
    end

    function automatic logic [7:0] model_step(input logic [7:0] v, input logic [5:0] pat);
        int hi, s, r;
        hi = -1;
        for (int i = 0; i < 6; i++) if (pat[i]) hi = i;
        if (hi < 0) return v;
        s = (hi >= 4) ? 1 : (hi >= 2) ? 2 : 8;
        r = (hi % 2 == 1) ? int'(v) - s : int'(v) + s;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    task automatic press(input logic [5:0] pat);
        @(negedge clk);
        btn = pat;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (4) @(negedge clk);
        if (!mode) mval[ch_sel] = model_step(mval[ch_sel], pat);
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1);
        exp_q.push_back('{addr: 1'b0, d: d0});
        exp_q.push_back('{addr: 1'b1, d: d1});
    endtask

    task automatic check_frame(input string tag);
        wait_fd();
        push_frame(mval[0], mval[1]);
        wait_fd();
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int f, ph, ch;
        mval[0] = 8'h80;
        mval[1] = 8'h80;

        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(dac_csn), 32'd1);
        chk("rst_wrn", 32'(dac_wrn), 32'd1);
        chk("rst_ldacn", 32'(dac_ldacn), 32'd1);
        chk("rst_d", 32'(dac_d), 32'h00);
        chk("rst_led", 32'(led_out), 32'h80);
        chk("rst_fd", 32'(frame_done), 32'd0);

        // Cycle-exact walk through the first frame and into the second frame's first strobe.
        rst = 1'b0;
        for (int k = 0; k <= 25; k++) begin
            #1;
            f = k % 19;
            ch = (f - 4) / 7;
            if (f < 4) ph = 0;
            else if (f == 18) ph = 4;
            else if ((f - 4) % 7 < 2) ph = 1;
            else if ((f - 4) % 7 < 5) ph = 2;
            else ph = 3;
            chk($sformatf("c%0d_wrn", k), 32'(dac_wrn), 32'(ph != 2));
            chk($sformatf("c%0d_csn", k), 32'(dac_csn), 32'(ph == 0 || ph == 4));
            chk($sformatf("c%0d_ldacn", k), 32'(dac_ldacn), 32'(ph != 4));
            chk($sformatf("c%0d_fd", k), 32'(frame_done), 32'(k == 19));
            if (ph >= 1 && ph <= 3) begin
                chk($sformatf("c%0d_addr", k), 32'(dac_addr), 32'(ch));
                chk($sformatf("c%0d_d", k), 32'(dac_d), 32'h80);
            end
            if (k < 25) @(negedge clk);
        end

        // Now mid-strobe: reset must release wrn immediately.
        rst = 1'b1;
        #1;
        chk("rst_wr_wrn", 32'(dac_wrn), 32'd1);
        chk("rst_wr_csn", 32'(dac_csn), 32'd1);
        repeat (2) @(negedge clk);
        chk("rst_wr_d", 32'(dac_d), 32'h00);
        chk("rst_wr_led", 32'(led_out), 32'h80);
        rst = 1'b0;
        check_frame("frame_after_rst");

        ch_sel = 1'b1;
        for (int i = 0; i < 15; i++) press(6'b000001);
        chk("ch1_15_led", 32'(led_out), 32'(mval[1]));
        press(6'b000001);
        chk("ch1_sat_led", 32'(led_out), 32'hFF);
        press(6'b000001);
        chk("ch1_sat_hold", 32'(led_out), 32'(mval[1]));
        check_frame("frame_ch1_ff");

        ch_sel = 1'b0;
        for (int i = 0; i < 15; i++) press(6'b000010);
        for (int i = 0; i < 3; i++) press(6'b001000);
        press(6'b100000);
        chk("ch0_01_led", 32'(led_out), 32'h01);
        press(6'b001000);
        chk("ch0_floor_led", 32'(led_out), 32'h00);
        press(6'b100000);
        chk("ch0_floor_hold", 32'(led_out), 32'h00);
        check_frame("frame_ch0_00");

        for (int i = 0; i < 16; i++) press(6'b000001);
        chk("ch0_back_mid", 32'(led_out), 32'(mval[0]));
        press(6'b110000);
        chk("prio_led", 32'(led_out), 32'h7F);
        check_frame("frame_prio");

        for (int i = 0; i < 16; i++) press(6'b000001);
        press(6'b100000);
        chk("ch0_fe_led", 32'(led_out), 32'hFE);

        // Ramp: enable after a frame_done so the next frame still carries 0xFE.
        wait_fd();
        @(negedge clk);
        mode = 1'b1;
        push_frame(8'hFE, mval[1]);
        press(6'b000001);
        wait_fd();
        chk("ramp_f0_drained", 32'(exp_q.size()), 32'd0);
        push_frame(8'hFF, mval[1]);
        wait_fd();
        chk("ramp_f1_drained", 32'(exp_q.size()), 32'd0);
        push_frame(8'h00, mval[1]);
        wait_fd();
        chk("ramp_f2_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        chk("ramp_led", 32'(led_out), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
